wb_select_sequencer: RTL

Register write-back select sequencer for the SCM16 datapath. It accepts destination-register requests as a start index plus a write count, buffers up to two requests, and steps through the indices one per cycle. Each cycle it drives a 4-bit select and an active-high disable straight into the 4-to-16 write-enable decoder (DEC4). While no write is due, the decoder is held disabled, so no register-file write enable is asserted.

---
 rtl/wb_select_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/wb_select_sequencer.sv
// wb_select_sequencer: write-back select sequencer driving a 4-to-16
// write-enable decoder. It queues up to two {index, count} requests and walks
// through consecutive register indices, one per cycle.
// Optional feature macro: WBSEL_STALL_EN adds a stall input that freezes
// stepping and forces the decoder disabled while asserted in RUN.
module wb_select_sequencer #(
    parameter int UUID = 0,
    parameter     NAME = ""
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_index,
    input  logic [3:0] req_count,
`ifdef WBSEL_STALL_EN
    input  logic       stall,
`endif
    output logic       Bit_1,
    output logic       Bit_2,
    output logic       Bit_3,
    output logic       Bit_4,
    output logic       Disable,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Instance identification only; it has no effect on the logic.
    logic unused_params;
    assign unused_params = (UUID == 0) ^ (NAME == "");

    // Register index arithmetic is modulo 16: index 15 steps to index 0.
    function automatic logic [3:0] idx_step(input logic [3:0] idx);
        return idx + 4'd1;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cur_idx_q, cur_idx_d;
    logic [3:0] remain_q, remain_d;
    logic       done_q, done_d;
    logic       dis_q;
    logic       busy_q;
    logic       ready_q;

    // Two-entry request queue; payload regs carry no reset, pointers do.
    logic [3:0] fifo_idx [0:1];
    logic [3:0] fifo_cnt [0:1];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q, occ_d;

    logic push;
    logic pop;
    logic hold;
    logic fifo_nonempty;

`ifdef WBSEL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign push          = req_valid & ready_q;
    assign fifo_nonempty = (occ_q != 2'd0);

    // Next-state logic: load from the queue head, step the index, end bursts.
    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        remain_d  = remain_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_nonempty && !hold) begin
                    pop       = 1'b1;
                    cur_idx_d = fifo_idx[rd_ptr_q];
                    remain_d  = fifo_cnt[rd_ptr_q];
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (remain_q != 4'd0) begin
                        cur_idx_d = idx_step(cur_idx_q);
                        remain_d  = remain_q - 4'd1;
                    end else begin
                        done_d = 1'b1;
                        if (fifo_nonempty) begin
                            // Chain straight into the next request: no bubble.
                            pop       = 1'b1;
                            cur_idx_d = fifo_idx[rd_ptr_q];
                            remain_d  = fifo_cnt[rd_ptr_q];
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue occupancy after this edge's push and pop.
    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Control state, registered outputs and queue pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cur_idx_q <= 4'd0;
            remain_q  <= 4'd0;
            done_q    <= 1'b0;
            dis_q     <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
            remain_q  <= remain_d;
            done_q    <= done_d;
            dis_q     <= (state_d != RUN);
            busy_q    <= (state_d == RUN);
            ready_q   <= (occ_d != 2'd2);
            occ_q     <= occ_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Queue payload storage, written on accept.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr_q] <= req_index;
            fifo_cnt[wr_ptr_q] <= req_count;
        end
    end

    assign req_ready = ready_q;
    assign Bit_1     = cur_idx_q[0];
    assign Bit_2     = cur_idx_q[1];
    assign Bit_3     = cur_idx_q[2];
    assign Bit_4     = cur_idx_q[3];
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef WBSEL_STALL_EN
    // A stall in RUN masks the decoder in the same cycle.
    assign Disable = dis_q | (stall & busy_q);
`else
    assign Disable = dis_q;
`endif

endmodule
